// File: rtl/stage_pkg.sv
// Shared definitions for the decode stage: bundle layouts, ALU op indices and opcode patterns.
package stage_pkg;

    // Execute-bound bundle, MSB first: {pc, alu_op, src1, src2, rkd_value, dest, gr_we, mem_we,
    // res_from_mem}.
    localparam int unsigned ST2TO3_W = 148;

    localparam int unsigned OffResFromMem = 0;
    localparam int unsigned OffMemWe      = 1;
    localparam int unsigned OffGrWe       = 2;
    localparam int unsigned OffDest       = 3;
    localparam int unsigned OffRkdValue   = 8;
    localparam int unsigned OffAluSrc2    = 40;
    localparam int unsigned OffAluSrc1    = 72;
    localparam int unsigned OffAluOp      = 104;
    localparam int unsigned OffPc         = 116;

    // Forwarding buses carry every listed field: {valid, gr_we, is_load, dest, value} and
    // {valid, gr_we, dest, value}.
    localparam int unsigned EX_FWD_W  = 40;
    localparam int unsigned MEM_FWD_W = 39;

    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluSlt  = 2;
    localparam int unsigned AluSltu = 3;
    localparam int unsigned AluAnd  = 4;
    localparam int unsigned AluNor  = 5;
    localparam int unsigned AluOr   = 6;
    localparam int unsigned AluXor  = 7;
    localparam int unsigned AluSll  = 8;
    localparam int unsigned AluSrl  = 9;
    localparam int unsigned AluSra  = 10;
    localparam int unsigned AluLui  = 11;

    // Matched against inst[31:15].
    localparam logic [16:0] OpAddW  = 17'h00020;
    localparam logic [16:0] OpSubW  = 17'h00022;
    localparam logic [16:0] OpSlt   = 17'h00024;
    localparam logic [16:0] OpSltu  = 17'h00025;
    localparam logic [16:0] OpNor   = 17'h00028;
    localparam logic [16:0] OpAnd   = 17'h00029;
    localparam logic [16:0] OpOr    = 17'h0002A;
    localparam logic [16:0] OpXor   = 17'h0002B;
    localparam logic [16:0] OpSlliW = 17'h00081;
    localparam logic [16:0] OpSrliW = 17'h00089;
    localparam logic [16:0] OpSraiW = 17'h00091;

    // Matched against inst[31:22].
    localparam logic [9:0] OpAddiW = 10'h00A;
    localparam logic [9:0] OpLdW   = 10'h0A2;
    localparam logic [9:0] OpStW   = 10'h0A6;

    // Matched against inst[31:25].
    localparam logic [6:0] OpLu12iW = 7'h0A;

    // Matched against inst[31:26].
    localparam logic [5:0] OpJirl = 6'h13;
    localparam logic [5:0] OpB    = 6'h14;
    localparam logic [5:0] OpBl   = 6'h15;
    localparam logic [5:0] OpBeq  = 6'h16;
    localparam logic [5:0] OpBne  = 6'h17;

    typedef struct packed {
        logic        valid;
        logic        gr_we;
        logic        is_load;
        logic [4:0]  dest;
        logic [31:0] value;
    } ex_fwd_t;

    typedef struct packed {
        logic        valid;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] value;
    } mem_fwd_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [31:0] alu_src1;
        logic [31:0] alu_src2;
        logic [31:0] rkd_value;
        logic [4:0]  dest;
        logic        gr_we;
        logic        mem_we;
        logic        res_from_mem;
    } st2to3_t;

    function automatic logic [31:0] sext_offs16(input logic [15:0] offs);
        return {{14{offs[15]}}, offs, 2'b00};
    endfunction

    function automatic logic [31:0] sext_offs26(input logic [25:0] offs);
        return {{4{offs[25]}}, offs, 2'b00};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 reads zero,
// and a same-cycle write is bypassed to the reads.
module regfile (
    input  logic        clk,
    input  logic [4:0]  raddr1_i,
    output logic [31:0] rdata1_o,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata2_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] rf_q [32];

    always_ff @(posedge clk) begin
        if (we_i && (waddr_i != 5'd0)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = rf_q[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = 32'd0;
        end else if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = rf_q[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = 32'd0;
        end else if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/stage_2_id.sv
// Decode stage: stage register, decode, register read, hazard handling and branch resolution.
// Define ID_FWD_EN to forward ex/mem results and stall only on load-use.
module stage_2_id #(
    parameter int unsigned ST2TO3_W = stage_pkg::ST2TO3_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_1,
    output logic                           allow_2,
    input  logic [63:0]                    stage_1_to_2,
    output logic                           br_taken,
    output logic [31:0]                    br_target,
    output logic                           valid_2,
    input  logic                           allow_3,
    output logic [ST2TO3_W-1:0]            stage_2_to_3,
    input  logic [stage_pkg::EX_FWD_W-1:0]  ex_fwd,
    input  logic [stage_pkg::MEM_FWD_W-1:0] mem_fwd,
    input  logic                           rf_we,
    input  logic [4:0]                     rf_waddr,
    input  logic [31:0]                    rf_wdata
);

    import stage_pkg::*;

    logic        valid_r;
    logic [31:0] inst_r;
    logic [31:0] pc_r;
    logic        ready_go;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= 1'b0;
        end else if (allow_2) begin
            valid_r <= valid_1 & ~br_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_r <= 32'd0;
            pc_r   <= 32'd0;
        end else if (allow_2 && valid_1) begin
            {inst_r, pc_r} <= stage_1_to_2;
        end
    end

    // Instruction fields
    logic [4:0]  rd, rj, rk;
    logic [11:0] i12;
    logic [15:0] i16;
    logic [19:0] i20;
    logic [25:0] i26;

    assign rd  = inst_r[4:0];
    assign rj  = inst_r[9:5];
    assign rk  = inst_r[14:10];
    assign i12 = inst_r[21:10];
    assign i16 = inst_r[25:10];
    assign i20 = inst_r[24:5];
    assign i26 = {inst_r[9:0], inst_r[25:10]};

    logic inst_add_w, inst_sub_w, inst_slt, inst_sltu, inst_and, inst_or, inst_nor, inst_xor;
    logic inst_slli_w, inst_srli_w, inst_srai_w, inst_addi_w, inst_lu12i_w;
    logic inst_ld_w, inst_st_w, inst_b, inst_bl, inst_beq, inst_bne, inst_jirl;

    assign inst_add_w   = inst_r[31:15] == OpAddW;
    assign inst_sub_w   = inst_r[31:15] == OpSubW;
    assign inst_slt     = inst_r[31:15] == OpSlt;
    assign inst_sltu    = inst_r[31:15] == OpSltu;
    assign inst_and     = inst_r[31:15] == OpAnd;
    assign inst_or      = inst_r[31:15] == OpOr;
    assign inst_nor     = inst_r[31:15] == OpNor;
    assign inst_xor     = inst_r[31:15] == OpXor;
    assign inst_slli_w  = inst_r[31:15] == OpSlliW;
    assign inst_srli_w  = inst_r[31:15] == OpSrliW;
    assign inst_srai_w  = inst_r[31:15] == OpSraiW;
    assign inst_addi_w  = inst_r[31:22] == OpAddiW;
    assign inst_ld_w    = inst_r[31:22] == OpLdW;
    assign inst_st_w    = inst_r[31:22] == OpStW;
    assign inst_lu12i_w = inst_r[31:25] == OpLu12iW;
    assign inst_jirl    = inst_r[31:26] == OpJirl;
    assign inst_b       = inst_r[31:26] == OpB;
    assign inst_bl      = inst_r[31:26] == OpBl;
    assign inst_beq     = inst_r[31:26] == OpBeq;
    assign inst_bne     = inst_r[31:26] == OpBne;

    logic inst_3r, inst_shift, inst_known;

    assign inst_3r    = inst_add_w | inst_sub_w | inst_slt | inst_sltu |
                        inst_and | inst_or | inst_nor | inst_xor;
    assign inst_shift = inst_slli_w | inst_srli_w | inst_srai_w;
    assign inst_known = inst_3r | inst_shift | inst_addi_w | inst_lu12i_w | inst_ld_w |
                        inst_st_w | inst_b | inst_bl | inst_beq | inst_bne | inst_jirl;

    logic [11:0] alu_op;

    always_comb begin
        alu_op          = '0;
        alu_op[AluAdd]  = inst_add_w | inst_addi_w | inst_ld_w | inst_st_w | inst_bl | inst_jirl;
        alu_op[AluSub]  = inst_sub_w;
        alu_op[AluSlt]  = inst_slt;
        alu_op[AluSltu] = inst_sltu;
        alu_op[AluAnd]  = inst_and;
        alu_op[AluNor]  = inst_nor;
        alu_op[AluOr]   = inst_or;
        alu_op[AluXor]  = inst_xor;
        alu_op[AluSll]  = inst_slli_w;
        alu_op[AluSrl]  = inst_srli_w;
        alu_op[AluSra]  = inst_srai_w;
        alu_op[AluLui]  = inst_lu12i_w;
    end

    logic        src2_is_imm;
    logic [31:0] imm;
    logic [31:0] br_offs;

    assign src2_is_imm = inst_addi_w | inst_ld_w | inst_st_w | inst_shift | inst_lu12i_w;

    always_comb begin
        imm = {{20{i12[11]}}, i12};
        if (inst_shift) begin
            imm = {27'd0, rk};
        end else if (inst_lu12i_w) begin
            imm = {i20, 12'd0};
        end
    end

    assign br_offs = (inst_b | inst_bl) ? sext_offs26(i26) : sext_offs16(i16);

    logic       uses_rj, uses_rkd;
    logic [4:0] rkd_reg;
    logic [4:0] dest;
    logic       gr_we;

    assign uses_rj  = inst_known & ~(inst_b | inst_bl | inst_lu12i_w);
    assign uses_rkd = inst_3r | inst_beq | inst_bne | inst_st_w;
    assign rkd_reg  = (inst_beq | inst_bne | inst_st_w) ? rd : rk;
    assign dest     = inst_bl ? 5'd1 : rd;
    assign gr_we    = (inst_3r | inst_shift | inst_addi_w | inst_lu12i_w | inst_ld_w |
                       inst_bl | inst_jirl) & (dest != 5'd0);

    logic [31:0] rf_rdata1, rf_rdata2;

    regfile u_regfile (
        .clk      (clk),
        .raddr1_i (rj),
        .rdata1_o (rf_rdata1),
        .raddr2_i (rkd_reg),
        .rdata2_o (rf_rdata2),
        .we_i     (rf_we),
        .waddr_i  (rf_waddr),
        .wdata_i  (rf_wdata)
    );

    // WB producers need no handling here: the register file read already sees them.
    ex_fwd_t  ex;
    mem_fwd_t mem;
    logic     ex_hit_j, ex_hit_k, mem_hit_j, mem_hit_k;

    assign ex  = ex_fwd;
    assign mem = mem_fwd;

    assign ex_hit_j  = uses_rj & (rj != 5'd0) & ex.valid & ex.gr_we & (ex.dest == rj);
    assign ex_hit_k  = uses_rkd & (rkd_reg != 5'd0) & ex.valid & ex.gr_we & (ex.dest == rkd_reg);
    assign mem_hit_j = uses_rj & (rj != 5'd0) & mem.valid & mem.gr_we & (mem.dest == rj);
    assign mem_hit_k = uses_rkd & (rkd_reg != 5'd0) & mem.valid & mem.gr_we &
                       (mem.dest == rkd_reg);

    logic [31:0] rj_value, rkd_value;

`ifdef ID_FWD_EN
    assign rj_value  = ex_hit_j ? ex.value : (mem_hit_j ? mem.value : rf_rdata1);
    assign rkd_value = ex_hit_k ? ex.value : (mem_hit_k ? mem.value : rf_rdata2);
    assign ready_go  = ~((ex_hit_j | ex_hit_k) & ex.is_load);
`else
    logic unused_fwd;

    assign rj_value   = rf_rdata1;
    assign rkd_value  = rf_rdata2;
    assign ready_go   = ~(ex_hit_j | ex_hit_k | mem_hit_j | mem_hit_k);
    assign unused_fwd = ^{ex.is_load, ex.value, mem.value};
`endif

    logic br_cond;

    assign br_cond   = inst_b | inst_bl | inst_jirl |
                       (inst_beq & (rj_value == rkd_value)) |
                       (inst_bne & (rj_value != rkd_value));
    assign br_target = inst_jirl ? (rj_value + br_offs) : (pc_r + br_offs);
    assign br_taken  = valid_r & ready_go & allow_3 & br_cond;

    assign allow_2 = ~valid_r | (ready_go & allow_3);
    assign valid_2 = valid_r & ready_go;

    st2to3_t bundle;

    always_comb begin
        bundle              = '0;
        bundle.pc           = pc_r;
        bundle.alu_op       = alu_op;
        bundle.alu_src1     = (inst_bl | inst_jirl) ? pc_r : rj_value;
        bundle.alu_src2     = (inst_bl | inst_jirl) ? 32'd4 : (src2_is_imm ? imm : rkd_value);
        bundle.rkd_value    = rkd_value;
        bundle.dest         = dest;
        bundle.gr_we        = gr_we;
        bundle.mem_we       = inst_st_w;
        bundle.res_from_mem = inst_ld_w;
    end

    assign stage_2_to_3 = bundle;

endmodule
